dcache_tag_ctrl: RTL and testbench
==================================

DCACHE_TAG_CTRL -- requirements
Module: dcache_tag_ctrl

Interface
REQ-001 Parameter ID_W, 16, AXI ID width.
REQ-002 Parameter AXI_ID, 1, constant ID driven on arid_o/awid_o/wid_o.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid/req_ready  in/out  1/1  lookup request handshake.
REQ-006 req_write  in  1  1 = write request, 0 = read request.
REQ-007 req_addr  in  64  byte address; bit 63 SHALL be 0; index = [31:6], tag = [62:32].
REQ-008 req_wdata  in  512  line write data.
REQ-009 resp_valid/resp_ready  out/in  1/1  response handshake.
REQ-010 resp_hit, resp_dirty  out  1,1  lookup hit; dirty bit of line read.
REQ-011 resp_data  out  512  line data read; resp_victim_tag out 31, stored tag field [60:30].
REQ-012 arid_o, araddr_o[63:0], arvalid_o out; arready_i in  AXI AR master.
REQ-013 rid_i, rdata_i[575:0] (tag word [575:512], data [511:0]), rvalid_i in; rready_o out.
REQ-014 awid_o, awaddr_o[63:0], awvalid_o, wid_o, wdata_o[511:0], wvalid_o out; awready_i, wready_i in.
REQ-015 bid_i, bvalid_i in; bready_o out.
REQ-016 hit_cnt, miss_cnt  out  32,32  statistics (see Configuration).

Function
REQ-017 FSM states IDLE, AR, R, AW_W, B, RESP; one request outstanding.
REQ-018 IDLE: req_ready=1; on req_valid capture addr/write/wdata, go AR.
REQ-019 AR: arvalid_o=1, araddr_o={req_addr[63:6],6'b0}; hold until arready_i, go R.
REQ-020 R: rready_o=1; on rvalid_i register tag word and data.
REQ-021 Tag word: bit63 valid, bit62 dirty, [61:30] stored tag incl. flag bit 61, [29:0] ignored.
REQ-022 hit = valid AND stored[60:30] == req_addr[62:32].
REQ-023 Read: R -> RESP next cycle; resp_data = line data, resp_hit, resp_dirty per stored word.
REQ-024 Write, hit or invalid line: R -> AW_W; awaddr_o={1'b1,req_addr[62:6],6'b0} (bit 63 marks dirty), wdata_o=req_wdata.
REQ-025 Write, valid line with tag mismatch: no write issued; R -> RESP, resp_hit=0, resp_dirty and resp_victim_tag = victim's.
REQ-026 AW_W: awvalid_o and wvalid_o asserted together, each held until its ready seen (same or different cycle); both done -> B.
REQ-027 B: bready_o=1; on bvalid_i go RESP; bid_i not checked.
REQ-028 RESP: resp_valid=1, outputs stable until resp_ready; then IDLE; write resp_hit reflects lookup before write.
REQ-029 Minimum latency req accept to resp_valid: 4 cycles read with zero-wait slave; responses never overlap requests.
REQ-030 rdata_i/rid_i sampled only in R with rvalid_i; AXI inputs outside expected state ignored.

Reset
REQ-031 rst asserted: state IDLE immediately; all valid/ready outputs 0 except req_ready=0; captured regs, resp_* and counters 0.
REQ-032 Reset mid-transaction abandons it with no replay; req_ready=1 first cycle after rst deassertion.

Configuration
REQ-033 DCACHE_STATS_EN defined: hit_cnt/miss_cnt increment once per completed lookup at RESP entry, saturating at 32'hFFFF_FFFF.
REQ-034 DCACHE_STATS_EN undefined: counter logic absent, hit_cnt/miss_cnt tied to 0, ports retained.

Structure
REQ-035 Package dcache_pkg: address/data/tag widths, index/offset/tag bit positions, tag-word field constants, FSM state enum.
REQ-036 Sub-module dcache_tag_cmp: combinational tag word + address -> hit, dirty, victim tag.

Verification
REQ-037 Read to empty memory addr 0x0000_0001_0000_0040 -> resp_hit=0, resp_dirty=0, no AW issued.
REQ-038 Write addr 0x0000_0001_0000_0040 data all 0xA5 -> AW addr 0x8000_0001_0000_0040; reread -> hit=1, dirty=1, data all 0xA5.
REQ-039 Write addr 0x0000_0002_0000_0040 after REQ-038 -> hit=0, dirty=1, victim_tag=0x0000_0001, no AW/W.
REQ-040 Slave holds awready 3 cycles after wready -> awvalid held until accepted; exactly one B consumed.
REQ-041 rst pulse while in B -> all valids 0 same cycle; next request completes normally.
REQ-042 With DCACHE_STATS_EN: 3 hits, 2 misses -> hit_cnt=3, miss_cnt=2; without macro both read 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared widths, bit positions and FSM encoding for the data-cache tag controller.
package dcache_pkg;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 512;
  localparam int TAGW_W    = 64;
  localparam int TAG_W     = 31;
  localparam int OFFSET_W  = 6;
  localparam int INDEX_LSB = 6;
  localparam int INDEX_MSB = 31;
  localparam int TAG_LSB   = 32;
  localparam int TAG_MSB   = 62;

  // Tag word layout as returned in the upper 64 bits of an R beat.
  localparam int TW_VALID   = 63;
  localparam int TW_DIRTY   = 62;
  localparam int TW_FLAG    = 61;
  localparam int TW_TAG_MSB = 60;
  localparam int TW_TAG_LSB = 30;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/dcache_tag_cmp.sv
// Combinational tag-word decode: hit, dirty and victim tag for a lookup address.
module dcache_tag_cmp
  import dcache_pkg::*;
(
  input  logic [TAGW_W-1:0] tag_word,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic              dirty,
  output logic [TAG_W-1:0]  victim_tag
);
  logic [TAG_W-1:0] stored_tag;
  logic             unused_bits;

  assign stored_tag = tag_word[TW_TAG_MSB:TW_TAG_LSB];
  assign hit        = tag_word[TW_VALID] && (stored_tag == addr[TAG_MSB:TAG_LSB]);
  assign dirty      = tag_word[TW_DIRTY];
  assign victim_tag = stored_tag;

  // The flag bit and low tag-word bits carry no meaning for the compare.
  assign unused_bits = ^{tag_word[TW_FLAG], tag_word[TW_TAG_LSB-1:0],
                         addr[ADDR_W-1], addr[TAG_LSB-1:0]};
endmodule

// File: rtl/dcache_tag_ctrl.sv
// Data-cache tag controller: AXI read of tag+line, compare, optional line write-back.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters.
module dcache_tag_ctrl
  import dcache_pkg::*;
#(
  parameter int ID_W   = 16,
  parameter int AXI_ID = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic                     resp_dirty,
  output logic [DATA_W-1:0]        resp_data,
  output logic [TAG_W-1:0]         resp_victim_tag,
  output logic [ID_W-1:0]          arid_o,
  output logic [ADDR_W-1:0]        araddr_o,
  output logic                     arvalid_o,
  input  logic                     arready_i,
  input  logic [ID_W-1:0]          rid_i,
  input  logic [TAGW_W+DATA_W-1:0] rdata_i,
  input  logic                     rvalid_i,
  output logic                     rready_o,
  output logic [ID_W-1:0]          awid_o,
  output logic [ADDR_W-1:0]        awaddr_o,
  output logic                     awvalid_o,
  input  logic                     awready_i,
  output logic [ID_W-1:0]          wid_o,
  output logic [DATA_W-1:0]        wdata_o,
  output logic                     wvalid_o,
  input  logic                     wready_i,
  input  logic [ID_W-1:0]          bid_i,
  input  logic                     bvalid_i,
  output logic                     bready_o,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt,
  output state_t                   dbg_state
);
  // Every channel transfers on a rising edge where its valid and ready are both high;
  // once raised, a valid stays high with stable payload until that transfer happens.
  state_t              state;
  logic                req_write_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic [TAGW_W-1:0]   tag_word_q;
  logic [DATA_W-1:0]   line_q;
  logic                got_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                cmp_hit;
  logic                cmp_dirty;
  logic [TAG_W-1:0]    cmp_victim;
  logic                go_aw_w;
  logic                unused_inputs;

  dcache_tag_cmp u_cmp (
    .tag_word   (tag_word_q),
    .addr       (req_addr_q),
    .hit        (cmp_hit),
    .dirty      (cmp_dirty),
    .victim_tag (cmp_victim)
  );

  // A write only goes to memory when it would not overwrite someone else's valid line.
  assign go_aw_w = req_write_q && (cmp_hit || !tag_word_q[TW_VALID]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      req_write_q     <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      tag_word_q      <= '0;
      line_q          <= '0;
      got_q           <= 1'b0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      resp_hit        <= 1'b0;
      resp_dirty      <= 1'b0;
      resp_data       <= '0;
      resp_victim_tag <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          req_write_q <= req_write;
          req_addr_q  <= req_addr;
          req_wdata_q <= req_wdata;
          state       <= S_AR;
        end
        S_AR: if (arready_i) state <= S_R;
        S_R: begin
          if (!got_q) begin
            if (rvalid_i) begin
              tag_word_q <= rdata_i[TAGW_W+DATA_W-1:DATA_W];
              line_q     <= rdata_i[DATA_W-1:0];
              got_q      <= 1'b1;
            end
          end else begin
            // Compare runs one cycle after capture, off the registered tag word.
            got_q           <= 1'b0;
            resp_hit        <= cmp_hit;
            resp_dirty      <= cmp_dirty;
            resp_data       <= line_q;
            resp_victim_tag <= cmp_victim;
            aw_done_q       <= 1'b0;
            w_done_q        <= 1'b0;
            state           <= go_aw_w ? S_AW_W : S_RESP;
          end
        end
        S_AW_W: begin
          if (awready_i) aw_done_q <= 1'b1;
          if (wready_i)  w_done_q  <= 1'b1;
          if ((aw_done_q || awready_i) && (w_done_q || wready_i)) state <= S_B;
        end
        S_B:    if (bvalid_i) state <= S_RESP;
        S_RESP: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE) && !rst;
  assign arvalid_o  = (state == S_AR);
  assign rready_o   = (state == S_R) && !got_q;
  assign awvalid_o  = (state == S_AW_W) && !aw_done_q;
  assign wvalid_o   = (state == S_AW_W) && !w_done_q;
  assign bready_o   = (state == S_B);
  assign resp_valid = (state == S_RESP);
  assign dbg_state  = state;

  assign arid_o   = ID_W'(AXI_ID);
  assign awid_o   = ID_W'(AXI_ID);
  assign wid_o    = ID_W'(AXI_ID);
  assign araddr_o = {req_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  // Address bit 63 on the write tells memory the line is now dirty.
  assign awaddr_o = {1'b1, req_addr_q[ADDR_W-2:OFFSET_W], {OFFSET_W{1'b0}}};
  assign wdata_o  = req_wdata_q;

  assign unused_inputs = ^{rid_i, bid_i, req_addr_q[OFFSET_W-1:0]};

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;
  logic        enter_resp;
  logic        enter_hit;

  assign enter_resp = ((state == S_R) && got_q && !go_aw_w) || ((state == S_B) && bvalid_i);
  assign enter_hit  = (state == S_R) ? cmp_hit : resp_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (enter_resp) begin
      if (enter_hit) hit_q  <= sat_inc(hit_q);
      else           miss_q <= sat_inc(miss_q);
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Self-checking bench for dcache_tag_ctrl: AXI slave memory, line-level reference model.
module tb_dcache_tag_ctrl;
  import dcache_pkg::*;

  localparam int ID_W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [63:0]  req_addr = '0;
  logic [511:0] req_wdata = '0;
  logic         resp_valid, resp_ready = 1'b0, resp_hit, resp_dirty;
  logic [511:0] resp_data;
  logic [30:0]  resp_victim_tag;
  logic [15:0]  arid_o, awid_o, wid_o, rid_i = '0, bid_i = '0;
  logic [63:0]  araddr_o, awaddr_o;
  logic         arvalid_o, arready_i = 1'b0, rvalid_i = 1'b0, rready_o;
  logic [575:0] rdata_i = '0;
  logic         awvalid_o, awready_i = 1'b0, wvalid_o, wready_i = 1'b0;
  logic [511:0] wdata_o;
  logic         bvalid_i = 1'b0, bready_o;
  logic [31:0]  hit_cnt, miss_cnt;
  state_t       dbg_state;

  always #5 clk = ~clk;

  dcache_tag_ctrl #(.ID_W(ID_W), .AXI_ID(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_dirty(resp_dirty), .resp_data(resp_data), .resp_victim_tag(resp_victim_tag),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // Reference model: one entry per cache index, what the line should hold.
  typedef struct packed {
    logic         valid;
    logic         dirty;
    logic [30:0]  tag;
    logic [511:0] data;
  } line_t;

  line_t        model [int];
  logic [575:0] slv_mem [int];

  int n_assert = 0, n_fail = 0;
  int exp_hits = 0, exp_misses = 0;
  int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0, resp_lat = 0;

  // Results of the last transaction
  logic         r_hit, r_dirty, done, aw_drop, resp_unstable;
  logic [30:0]  r_victim;
  logic [511:0] r_data, r_wdata;
  logic [63:0]  r_araddr, r_awaddr;
  int           n_ar, n_aw, n_w, n_b, lat;

  task automatic check(input string name, input logic [575:0] obs, input logic [575:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [575:0] slv_line(input int idx);
    return slv_mem.exists(idx) ? slv_mem[idx] : '0;
  endfunction

  function automatic line_t model_line(input int idx);
    return model.exists(idx) ? model[idx] : '0;
  endfunction

  task automatic idle_inputs();
    arready_i = 1'b0; rvalid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0;
    bvalid_i = 1'b0; resp_ready = 1'b0; req_valid = 1'b0;
  endtask

  task automatic check_cnt(input string name, input int hits, input int misses);
`ifdef DCACHE_STATS_EN
    check({name, "_hit_cnt"}, hit_cnt, 32'(hits));
    check({name, "_miss_cnt"}, miss_cnt, 32'(misses));
`else
    check({name, "_hit_cnt"}, hit_cnt, 32'(hits & 0));
    check({name, "_miss_cnt"}, miss_cnt, 32'(misses & 0));
`endif
  endtask

  task automatic reset_in_flight();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_valids", {req_ready, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid}, 7'b0);
    check("rst_resp", {resp_hit, resp_dirty, resp_victim_tag}, 33'b0);
    check("rst_cnt", {hit_cnt, miss_cnt}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("req_ready_after_rst", req_ready, 1'b1);
  endtask

  // Drives one request and plays the AXI slave cycle by cycle at posedge+1.
  task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [511:0] wd, input bit abort);
    bit f_req, f_ar, f_r, f_aw, f_w, f_b, f_resp, r_pend, b_pend, b_sched, aw_wait, snap_ok;
    int ar_c, r_c, aw_c, w_c, b_c, rs_c, acc_step, resp_step, r_idx;
    logic [544:0] snap;
    r_pend = 0; b_pend = 0; b_sched = 0; aw_wait = 0; snap_ok = 0; snap = '0;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0; rs_c = 0;
    acc_step = -1; resp_step = -1; r_idx = 0;
    n_ar = 0; n_aw = 0; n_w = 0; n_b = 0; lat = -1;
    aw_drop = 0; resp_unstable = 0; done = 0;
    req_write = wr; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int step = 0; step < 400 && !done; step++) begin
      f_req = req_valid && req_ready;
      if (f_req) acc_step = step;
      arready_i = arvalid_o && (ar_c >= ar_lat);
      if (arvalid_o && !arready_i) ar_c++;
      f_ar = arvalid_o && arready_i;
      if (f_ar) r_araddr = araddr_o;
      rvalid_i = r_pend && (r_c >= r_lat);
      if (r_pend && !rvalid_i) r_c++;
      rdata_i = rvalid_i ? slv_line(r_idx) : {rand_line(), $urandom, $urandom};
      rid_i = 16'($urandom);
      f_r = rvalid_i && rready_o;
      if (aw_wait && !awvalid_o) aw_drop = 1'b1;
      awready_i = awvalid_o && (aw_c >= aw_lat);
      if (awvalid_o && !awready_i) aw_c++;
      f_aw = awvalid_o && awready_i;
      aw_wait = awvalid_o && !awready_i;
      if (f_aw) r_awaddr = awaddr_o;
      wready_i = wvalid_o && (w_c >= w_lat);
      if (wvalid_o && !wready_i) w_c++;
      f_w = wvalid_o && wready_i;
      if (f_w) r_wdata = wdata_o;
      bvalid_i = b_pend && (b_c >= b_lat);
      if (b_pend && !bvalid_i) b_c++;
      bid_i = 16'($urandom);
      f_b = bvalid_i && bready_o;
      if (resp_valid) begin
        if (!snap_ok) begin
          snap = {resp_hit, resp_dirty, resp_victim_tag, resp_data};
          snap_ok = 1; resp_step = step;
        end else if ({resp_hit, resp_dirty, resp_victim_tag, resp_data} !== snap) begin
          resp_unstable = 1'b1;
        end
      end
      resp_ready = resp_valid && (rs_c >= resp_lat);
      if (resp_valid && !resp_ready) rs_c++;
      f_resp = resp_valid && resp_ready;
      if (f_resp) begin
        r_hit = resp_hit; r_dirty = resp_dirty; r_victim = resp_victim_tag; r_data = resp_data;
      end
      if (abort && bready_o) begin
        reset_in_flight();
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (f_req) req_valid = 1'b0;
        if (f_ar) begin n_ar++; r_pend = 1; r_c = 0; r_idx = int'(r_araddr[31:6]); end
        if (f_r) r_pend = 0;
        if (f_aw) n_aw++;
        if (f_w) n_w++;
        if (n_aw > 0 && n_w > 0 && !b_sched) begin
          slv_mem[int'(r_awaddr[31:6])] = {1'b1, r_awaddr[63], 1'($urandom), r_awaddr[62:32],
                                           30'($urandom), r_wdata};
          b_sched = 1; b_pend = 1; b_c = 0;
        end
        if (f_b) begin b_pend = 0; n_b++; end
        if (f_resp) begin done = 1'b1; lat = resp_step - acc_step; end
      end
    end
    idle_inputs();
  endtask

  task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [511:0] wd, input bit abort);
    int idx;
    line_t l;
    logic [30:0] tag;
    bit e_hit, e_aw, zero_lat;
    idx = int'(addr[31:6]);
    tag = addr[62:32];
    l = model_line(idx);
    e_hit = l.valid && (l.tag == tag);
    e_aw = wr && (e_hit || !l.valid);
    zero_lat = (ar_lat == 0) && (r_lat == 0) && (resp_lat == 0);
    if (e_aw) model[idx] = {1'b1, 1'b1, tag, wd};
    run_txn(wr, addr, wd, abort);
    if (abort) begin
      exp_hits = 0; exp_misses = 0;
      return;
    end
    if (e_hit) exp_hits++; else exp_misses++;
    check("txn_done", done, 1'b1);
    check("resp_hit", r_hit, e_hit);
    check("resp_dirty", r_dirty, l.dirty);
    check("resp_victim_tag", r_victim, l.tag);
    check("resp_data", r_data, l.data);
    check("ar_count", n_ar, 1);
    check("araddr", r_araddr, {addr[63:6], 6'b0});
    check("aw_count", n_aw, e_aw);
    check("w_count", n_w, e_aw);
    check("b_count", n_b, e_aw);
    if (e_aw) begin
      check("awaddr", r_awaddr, {1'b1, addr[62:6], 6'b0});
      check("wdata", r_wdata, wd);
    end
    check("awvalid_held", aw_drop, 1'b0);
    check("resp_stable", resp_unstable, 1'b0);
    if (!wr && zero_lat) check("read_latency", lat, 4);
    check_cnt("stats", exp_hits, exp_misses);
  endtask

  logic [511:0] a5_line;
  logic [511:0] wd_keep;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valids", {req_ready, arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o, resp_valid}, 7'b0);
    check("reset_resp", {resp_hit, resp_dirty, resp_victim_tag, resp_data}, '0);
    check("reset_cnt", {hit_cnt, miss_cnt}, 64'h0);
    check("reset_state", dbg_state, S_IDLE);
    rst = 1'b0;
    #1;
    check("req_ready_after_reset", req_ready, 1'b1);
    check("axi_ids", {arid_o, awid_o, wid_o}, {3{16'd1}});

    // Read of empty memory
    do_txn(1'b0, 64'h0000_0001_0000_0040, '0, 0);
    check("empty_read_hit", r_hit, 1'b0);
    check("empty_read_no_aw", n_aw, 0);

    // Write A5 line, then read it back
    a5_line = {64{8'hA5}};
    do_txn(1'b1, 64'h0000_0001_0000_0040, a5_line, 0);
    check("a5_awaddr", r_awaddr, 64'h8000_0001_0000_0040);
    do_txn(1'b0, 64'h0000_0001_0000_0040, '0, 0);
    check("a5_reread_hit", {r_hit, r_dirty}, 2'b11);
    check("a5_reread_data", r_data, a5_line);

    // Conflicting write to the same index: no memory traffic
    do_txn(1'b1, 64'h0000_0002_0000_0040, rand_line(), 0);
    check("conflict_hit_dirty", {r_hit, r_dirty}, 2'b01);
    check("conflict_victim", r_victim, 31'h1);
    check("conflict_no_w", n_w, 0);

    // AW accepted three cycles after W
    w_lat = 0; aw_lat = 3;
    do_txn(1'b1, 64'h0000_0001_0000_0040, rand_line(), 0);
    check("aw_late_b_once", n_b, 1);
    aw_lat = 0;

    // Reset while waiting for B, then a normal request
    b_lat = 10;
    wd_keep = rand_line();
    do_txn(1'b1, 64'h0000_0001_0000_0040, wd_keep, 1);
    b_lat = 0;
    do_txn(1'b0, 64'h0000_0001_0000_0040, '0, 0);
    check("after_abort_data", r_data, wd_keep);

    // Three hits and two misses since the reset
    do_txn(1'b0, 64'h0000_0001_0000_0040, '0, 0);
    do_txn(1'b1, 64'h0000_0001_0000_0040, rand_line(), 0);
    do_txn(1'b0, 64'h0000_0001_0000_0240, '0, 0);
    do_txn(1'b0, 64'h0000_0002_0000_0040, '0, 0);
    check_cnt("three_two", 3, 2);

    // Randomised traffic over a few indices and tags
    for (int t = 0; t < 40; t++) begin
      int ix, tg;
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
      b_lat = $urandom_range(0, 3); resp_lat = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: ix = 1;
        1: ix = 2;
        2: ix = 3;
        default: ix = 5;
      endcase
      tg = $urandom_range(1, 3);
      do_txn(1'($urandom_range(0, 1)), {1'b0, 31'(tg), 26'(ix), 6'($urandom)}, rand_line(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
